// File: rtl/hv_sparse_pkg.sv
// Shared types and helpers for the segmented sparse-hypervector blocks.
//   coll_state_e : collector FSM states
//   idx_width()  : index width for a one-hot segment of a given length
//   slot_lsb()   : lsb of slot k in a packed index-form hypervector
//   dim_ok()     : parameter consistency check (D, segment length, segment count)
package hv_sparse_pkg;

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StCollect = 1'b1
  } coll_state_e;

  function automatic int unsigned idx_width(input int unsigned len);
    return $clog2(len);
  endfunction

  function automatic int unsigned slot_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

  function automatic bit dim_ok(input int unsigned d, input int unsigned len,
                                input int unsigned nb);
    return (d == len * nb) && (len >= 2) && ((len & (len - 1)) == 0) && (nb >= 2);
  endfunction

endpackage

// File: rtl/u_recv_hv_sparse_if.sv
// Segment stream in, index-form hypervector out, plus status flags.
//   in_sgmnt_valid/segment_hv_input : segment strobe and one-hot data (no backpressure)
//   hv_indices/hv_valid/hv_ready    : assembled vector on valid/ready handshake
//   hv_error                        : presented vector contains a malformed segment
//   bad_segment/overflow            : malformed-segment pulse, sticky dropped-vector flag
// master = producer/consumer side, slave = receiver.
interface u_recv_hv_sparse_if #(
  parameter int unsigned LENGTH_SEGMENT = 32,
  parameter int unsigned NB_OF_SEGMENTS = 32
);
  import hv_sparse_pkg::*;

  localparam int unsigned IDX_W = idx_width(LENGTH_SEGMENT);

  logic                            in_sgmnt_valid;
  logic [LENGTH_SEGMENT-1:0]       segment_hv_input;
  logic [NB_OF_SEGMENTS*IDX_W-1:0] hv_indices;
  logic                            hv_valid;
  logic                            hv_ready;
  logic                            hv_error;
  logic                            bad_segment;
  logic                            overflow;

  modport master (
    output in_sgmnt_valid, segment_hv_input, hv_ready,
    input  hv_indices, hv_valid, hv_error, bad_segment, overflow
  );

  modport slave (
    input  in_sgmnt_valid, segment_hv_input, hv_ready,
    output hv_indices, hv_valid, hv_error, bad_segment, overflow
  );

endinterface

// File: rtl/u_onehot_to_index.sv
// One-hot segment to bit-index encoder (combinational).
//   i_segment  : LENGTH_SEGMENT-bit segment
//   o_index    : position of the set bit (meaningful only when exactly one bit is set)
//   o_is_zero  : no bit set
//   o_is_multi : more than one bit set
module u_onehot_to_index
  import hv_sparse_pkg::*;
#(
  parameter int unsigned LENGTH_SEGMENT = 32,
  localparam int unsigned IDX_W = idx_width(LENGTH_SEGMENT)
) (
  input  logic [LENGTH_SEGMENT-1:0] i_segment,
  output logic [IDX_W-1:0]          o_index,
  output logic                      o_is_zero,
  output logic                      o_is_multi
);

  // OR of the positions of all set bits; exact for a one-hot input.
  always_comb begin
    o_index = '0;
    for (int unsigned i = 0; i < LENGTH_SEGMENT; i++) begin
      if (i_segment[i]) o_index = o_index | IDX_W'(i);
    end
  end

  assign o_is_zero  = ~|i_segment;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign o_is_multi = |(i_segment & (i_segment - LENGTH_SEGMENT'(1)));

endmodule

// File: rtl/u_recv_hv_sparse.sv
// Receiver for the segmented sparse-hypervector stream.
//   clk        : clock
//   arst_in    : asynchronous active-high reset
//   sync_clear : synchronous resync, drops the partial vector and clears overflow
//   bus        : segment input, double-buffered vector output and status flags
module u_recv_hv_sparse
  import hv_sparse_pkg::*;
#(
  parameter int unsigned D              = 1024,
  parameter int unsigned LENGTH_SEGMENT = 32,
  parameter int unsigned NB_OF_SEGMENTS = 32
) (
  input logic              clk,
  input logic              arst_in,
  input logic              sync_clear,
  u_recv_hv_sparse_if.slave bus
);

  localparam int unsigned IDX_W = idx_width(LENGTH_SEGMENT);
  localparam int unsigned CNT_W = $clog2(NB_OF_SEGMENTS);

  if (!dim_ok(D, LENGTH_SEGMENT, NB_OF_SEGMENTS)) begin : g_param_err
    $error("u_recv_hv_sparse: need D == LENGTH_SEGMENT*NB_OF_SEGMENTS, pow2 segment >= 2");
  end

  coll_state_e                          r_state, w_state_d;
  logic [CNT_W-1:0]                     r_cnt, w_cnt_d;
  logic [NB_OF_SEGMENTS-1:0][IDX_W-1:0] r_slot, w_slot_d;
  logic [NB_OF_SEGMENTS-1:0][IDX_W-1:0] r_out, w_out_d;
  logic r_err, w_err_d;
  logic r_out_err, w_out_err_d;
  logic r_valid, w_valid_d;
  logic r_bad, w_bad_d;
  logic r_ovf, w_ovf_d;

  logic [IDX_W-1:0] w_idx;
  logic w_zero, w_multi, w_seg_bad;
  logic w_accept, w_last, w_drain, w_load;

  u_onehot_to_index #(
    .LENGTH_SEGMENT(LENGTH_SEGMENT)
  ) u_enc (
    .i_segment (bus.segment_hv_input),
    .o_index   (w_idx),
    .o_is_zero (w_zero),
    .o_is_multi(w_multi)
  );

  assign w_seg_bad = w_zero || w_multi;
  // A clear in the same cycle discards the strobe.
  assign w_accept  = bus.in_sgmnt_valid && !sync_clear;
  assign w_last    = w_accept && (r_cnt == CNT_W'(NB_OF_SEGMENTS - 1));
  assign w_drain   = r_valid && bus.hv_ready;
  // Output slot is free if empty or being handed off this very cycle.
  assign w_load    = w_last && (!r_valid || w_drain);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:    if (w_accept) w_state_d = StCollect;
      StCollect: if (w_last)   w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
    if (sync_clear) w_state_d = StIdle;
  end

  always_comb begin
    w_cnt_d     = r_cnt;
    w_slot_d    = r_slot;
    w_out_d     = r_out;
    w_err_d     = r_err;
    w_out_err_d = r_out_err;
    w_valid_d   = r_valid;
    w_ovf_d     = r_ovf;
    w_bad_d     = w_accept && w_seg_bad;

    if (w_drain) w_valid_d = 1'b0;

    if (sync_clear) begin
      w_cnt_d = '0;
      w_err_d = 1'b0;
      w_ovf_d = 1'b0;
    end else if (w_accept) begin
      w_slot_d[r_cnt] = w_seg_bad ? '0 : w_idx;
      if (w_last) begin
        w_cnt_d = '0;
        w_err_d = 1'b0;
        if (w_load) begin
          w_out_d     = w_slot_d;
          w_out_err_d = r_err || w_seg_bad;
          w_valid_d   = 1'b1;
        end else begin
          w_ovf_d = 1'b1;
        end
      end else begin
        w_cnt_d = r_cnt + CNT_W'(1);
        w_err_d = r_err || w_seg_bad;
      end
    end
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_slot    <= '0;
      r_out     <= '0;
      r_err     <= 1'b0;
      r_out_err <= 1'b0;
      r_valid   <= 1'b0;
      r_bad     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_slot    <= w_slot_d;
      r_out     <= w_out_d;
      r_err     <= w_err_d;
      r_out_err <= w_out_err_d;
      r_valid   <= w_valid_d;
      r_bad     <= w_bad_d;
      r_ovf     <= w_ovf_d;
    end
  end

  assign bus.hv_indices  = r_out;
  assign bus.hv_valid    = r_valid;
  assign bus.hv_error    = r_out_err;
  assign bus.bad_segment = r_bad;
  assign bus.overflow    = r_ovf;

endmodule

// File: tb/tb_u_recv_hv_sparse.sv
module tb_u_recv_hv_sparse;

  localparam int unsigned LS = 32;
  localparam int unsigned NS = 32;
  localparam int unsigned IW = $clog2(LS);
  localparam int unsigned VW = NS * IW;

  logic clk = 1'b0;
  logic arst_in;
  logic sync_clear;
  int   checks = 0;
  int   failures = 0;

  u_recv_hv_sparse_if #(.LENGTH_SEGMENT(LS), .NB_OF_SEGMENTS(NS)) bus ();

  u_recv_hv_sparse #(
    .D(LS * NS),
    .LENGTH_SEGMENT(LS),
    .NB_OF_SEGMENTS(NS)
  ) dut (
    .clk       (clk),
    .arst_in   (arst_in),
    .sync_clear(sync_clear),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Transaction-level reference: a queue of collected indices and an output holding slot.
  int          part[$];
  bit          m_perr, m_valid, m_err, m_bad, m_ovf;
  logic [VW-1:0] m_out;

  typedef struct {
    logic [LS-1:0] seg;
    int            exp_idx;
    bit            exp_bad;
  } vec_t;
  vec_t tbl[8];

  function automatic int seg_index(input logic [LS-1:0] s);
    for (int i = 0; i < LS; i++) if (s[i]) return i;
    return 0;
  endfunction

  function automatic logic [VW-1:0] pattern(input int off);
    logic [VW-1:0] v = '0;
    for (int k = 0; k < NS; k++) v[k*IW +: IW] = IW'((k + off) % LS);
    return v;
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    part.delete();
    m_perr = 0; m_valid = 0; m_err = 0; m_bad = 0; m_ovf = 0; m_out = '0;
  endtask

  task automatic model_step(input bit v, input logic [LS-1:0] s, input bit c, input bit r);
    bit bad;
    if (m_valid && r) m_valid = 0;
    m_bad = 0;
    if (c) begin
      part.delete(); m_perr = 0; m_ovf = 0;
    end else if (v) begin
      bad = ($countones(s) != 1);
      m_bad = bad;
      part.push_back(bad ? 0 : seg_index(s));
      m_perr = m_perr | bad;
      if (part.size() == NS) begin
        if (!m_valid) begin
          m_valid = 1; m_err = m_perr;
          for (int k = 0; k < NS; k++) m_out[k*IW +: IW] = IW'(part[k]);
        end else begin
          m_ovf = 1;
        end
        part.delete(); m_perr = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("hv_valid", VW'(bus.hv_valid), VW'(m_valid));
    chk("bad_segment", VW'(bus.bad_segment), VW'(m_bad));
    chk("overflow", VW'(bus.overflow), VW'(m_ovf));
    if (m_valid) begin
      chk("hv_error", VW'(bus.hv_error), VW'(m_err));
      chk("hv_indices", bus.hv_indices, m_out);
    end
  endtask

  task automatic cycle(input bit v, input logic [LS-1:0] s, input bit c, input bit r);
    @(negedge clk);
    bus.in_sgmnt_valid = v; bus.segment_hv_input = s; sync_clear = c; bus.hv_ready = r;
    @(posedge clk); #1;
    model_step(v, s, c, r);
    compare_all();
  endtask

  task automatic send_vec(input int off, input bit r_body, input bit r_last);
    for (int k = 0; k < NS; k++)
      cycle(1'b1, LS'(1) << ((k + off) % LS), 1'b0, (k == NS - 1) ? r_last : r_body);
  endtask

  task automatic check_zero_outputs(input string name);
    chk({name, "_valid"}, VW'(bus.hv_valid), '0);
    chk({name, "_indices"}, bus.hv_indices, '0);
    chk({name, "_error"}, VW'(bus.hv_error), '0);
    chk({name, "_bad"}, VW'(bus.bad_segment), '0);
    chk({name, "_ovf"}, VW'(bus.overflow), '0);
  endtask

  initial begin
    bus.in_sgmnt_valid = 0; bus.segment_hv_input = '0; bus.hv_ready = 0;
    sync_clear = 0; arst_in = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_zero_outputs("reset");
    @(negedge clk) arst_in = 0;

    // Full vector back to back, downstream ready.
    send_vec(0, 1'b1, 1'b1);
    chk("vec0_valid", VW'(bus.hv_valid), VW'(1));
    chk("vec0_idx", bus.hv_indices, pattern(0));
    chk("vec0_err", VW'(bus.hv_error), '0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("vec0_drained", VW'(bus.hv_valid), '0);

    // Malformed segments 5 (zero) and 9 (two bits).
    for (int k = 0; k < NS; k++) begin
      cycle(1'b1, (k == 5) ? LS'(0) : (k == 9) ? LS'(32'h11) : LS'(1) << k, 1'b0, 1'b1);
      if (k == 5 || k == 9) chk("bad_pulse", VW'(bus.bad_segment), VW'(1));
    end
    chk("bad_err", VW'(bus.hv_error), VW'(1));
    chk("bad_slot5", VW'(bus.hv_indices[5*IW +: IW]), '0);
    chk("bad_slot9", VW'(bus.hv_indices[9*IW +: IW]), '0);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Stalled downstream: second vector dropped, first kept.
    send_vec(1, 1'b0, 1'b0);
    send_vec(2, 1'b0, 1'b0);
    chk("ovf_set", VW'(bus.overflow), VW'(1));
    chk("ovf_hold", bus.hv_indices, pattern(1));
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("ovf_only_first", VW'(bus.hv_valid), '0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("ovf_cleared", VW'(bus.overflow), '0);

    // Ready raised exactly on the second vector's last strobe.
    send_vec(3, 1'b0, 1'b0);
    send_vec(4, 1'b0, 1'b1);
    chk("race_no_ovf", VW'(bus.overflow), '0);
    chk("race_valid", VW'(bus.hv_valid), VW'(1));
    chk("race_idx", bus.hv_indices, pattern(4));
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Resync mid-vector; the strobe coinciding with clear is discarded.
    for (int k = 0; k < 10; k++) cycle(1'b1, LS'(1) << (31 - k), 1'b0, 1'b1);
    cycle(1'b1, LS'(1), 1'b1, 1'b1);
    send_vec(7, 1'b1, 1'b1);
    chk("clr_idx", bus.hv_indices, pattern(7));
    chk("clr_valid", VW'(bus.hv_valid), VW'(1));
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Table of encoder cases in the first eight slots.
    tbl[0] = '{32'h0000_0001, 0, 1'b0};
    tbl[1] = '{32'h8000_0000, 31, 1'b0};
    tbl[2] = '{32'h0001_0000, 16, 1'b0};
    tbl[3] = '{32'h0000_0000, 0, 1'b1};
    tbl[4] = '{32'h0000_0003, 0, 1'b1};
    tbl[5] = '{32'hFFFF_FFFF, 0, 1'b1};
    tbl[6] = '{32'h0000_0040, 6, 1'b0};
    tbl[7] = '{32'h0040_0000, 22, 1'b0};
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, tbl[i].seg, 1'b0, 1'b1);
      chk("tbl_bad", VW'(bus.bad_segment), VW'(tbl[i].exp_bad));
    end
    for (int k = 8; k < NS; k++) cycle(1'b1, LS'(1) << k, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      chk("tbl_idx", VW'(bus.hv_indices[i*IW +: IW]), VW'(tbl[i].exp_idx));
    chk("tbl_err", VW'(bus.hv_error), VW'(1));
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Asynchronous reset with a held vector and a partial one.
    send_vec(9, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) cycle(1'b1, LS'(1) << k, 1'b0, 1'b0);
    chk("pre_rst_valid", VW'(bus.hv_valid), VW'(1));
    #2;
    bus.in_sgmnt_valid = 0;
    arst_in = 1;
    #1 check_zero_outputs("arst");
    model_reset();
    @(negedge clk) arst_in = 0;
    send_vec(11, 1'b1, 1'b1);
    chk("post_rst_idx", bus.hv_indices, pattern(11));
    chk("post_rst_err", VW'(bus.hv_error), '0);

    // Randomized traffic against the reference.
    for (int n = 0; n < 3000; n++) begin
      logic [LS-1:0] s;
      int sel = $urandom_range(0, 9);
      bit r = (n % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      if (sel == 0) s = '0;
      else if (sel == 1) s = LS'($urandom);
      else s = LS'(1) << $urandom_range(0, LS - 1);
      cycle($urandom_range(0, 3) != 0, s, $urandom_range(0, 199) == 0, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/u_recv_hv_sparse.md
# u_recv_hv_sparse

Receiving end of the segmented sparse-hypervector stream. Accepts one LENGTH_SEGMENT-wide one-hot segment per strobe from the random sparse HV generator (or any segment-serial producer), encodes each segment to its bit index, and assembles NB_OF_SEGMENTS indices into a compact index-form hypervector. Completed vectors are double-buffered and offered downstream (associative memory, binding unit) on a valid/ready handshake; malformed segments and overruns are flagged.

## Interface
Parameters:
- D, 1024, hypervector dimension; must equal LENGTH_SEGMENT*NB_OF_SEGMENTS (elaboration-time check)
- LENGTH_SEGMENT, 32, bits per segment; power of two, ≥2
- NB_OF_SEGMENTS, 32, segments per hypervector; ≥2
- IDX_W (derived, not overridable), $clog2(LENGTH_SEGMENT), index width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state on rising edge
- arst_in  in  1  asynchronous active-high reset
- sync_clear  in  1  synchronous resync: drops partial vector, segment counter to 0
- in_sgmnt_valid  in  1  segment strobe; producer has no backpressure, every strobe is consumed
- segment_hv_input  in  LENGTH_SEGMENT  segment bits, sampled when in_sgmnt_valid=1
- hv_indices  out  NB_OF_SEGMENTS*IDX_W  assembled vector; segment k index at bits [k*IDX_W +: IDX_W]
- hv_valid  out  1  hv_indices/hv_error valid
- hv_ready  in  1  downstream accepts when hv_valid&&hv_ready
- hv_error  out  1  ≥1 malformed segment in presented vector
- bad_segment  out  1  one-cycle pulse: last accepted segment not one-hot
- overflow  out  1  sticky: completed vector dropped; cleared by reset or sync_clear

## Operation
- Collector FSM (package enum): IDLE (counter 0, no partial data) -> COLLECT on first accepted segment; COLLECT -> IDLE when segment NB_OF_SEGMENTS-1 is accepted; sync_clear forces IDLE from any state.
- Per accepted segment: index = position of the single set bit, written to collect slot[counter]; counter increments, wraps to 0 after NB_OF_SEGMENTS-1.
- Malformed segment (zero bits or >1 bit set): slot written 0, bad_segment pulses, per-vector error bit set.
- On last segment: collect buffer + error bit transfer to output buffer if output empty, or being drained (hv_valid&&hv_ready) in that same cycle. Otherwise vector is dropped, overflow set, output buffer unchanged.
- Output buffer holds stable while hv_valid=1 and hv_ready=0; cleared valid on handshake.
- sync_clear does not affect a vector already in the output buffer.
- sync_clear and in_sgmnt_valid same cycle: clear wins, segment discarded.

## Timing
- Reset values: hv_valid=0, hv_indices=0, hv_error=0, bad_segment=0, overflow=0; FSM IDLE, counter 0, error bit 0.
- Reset mid-vector: partial vector and buffered output discarded immediately (asynchronous).
- Latency: hv_valid rises the cycle after the edge accepting the last segment.
- bad_segment asserted in the cycle after the offending strobe, for exactly one cycle.
- Back-to-back strobes every cycle supported indefinitely if downstream keeps hv_ready=1.
- Handshake completing in the same cycle as a new transfer: hv_valid stays 1 with new data next cycle, no bubble.
- overflow rises the cycle after the dropping edge.

## Structure
- Package hv_sparse_pkg: collector state enum (IDLE, COLLECT), function for IDX_W/index slicing, D consistency check helper.
- Sub-module u_onehot_to_index: combinational, LENGTH_SEGMENT in -> IDX_W index, is_zero, is_multi flags; reused by other sparse-HV blocks.
- Top holds FSM, counter, collect and output buffers.

## Test plan
- Reset, then 32 strobes with segment k = 1<<(k%32) back to back, hv_ready=1 -> hv_valid pulse one cycle after strobe 31, slot k = k%32, hv_error=0.
- Segment 5 = 0 and segment 9 = 0x00000011 -> bad_segment pulses after strobes 5 and 9, slots 5 and 9 read 0, hv_error=1.
- hv_ready=0, stream two full vectors -> first held stable, overflow=1 after second vector's last strobe; hv_ready=1 yields first vector only.
- hv_ready raised exactly in cycle of second vector's last strobe -> no overflow, second vector presented next cycle.
- sync_clear after 10 segments, then 32 new segments -> output contains only new segments; sync_clear together with a strobe discards that strobe.
- arst_in asserted mid-vector with hv_valid=1 -> all outputs 0 asynchronously; next 32 strobes assemble a correct vector.
